// File: rtl/key_filter_multi.sv
// N-channel key debouncer: per-channel press/release/long-press (and optional auto-repeat, KEY_REPEAT_EN) pulses.
// Latency: press/release flag and key_state update DEBOUNCE_CYCLES+2 edges after the first edge sampling a new pin level.
// Backpressure: none; all outputs are registered single-cycle pulses or levels, channels fully independent.
module key_filter_multi #(
    parameter int NUM_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int REPEAT_CYCLES     = 10_000_000,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] press_flag,
    output logic [NUM_KEYS-1:0] release_flag,
    output logic [NUM_KEYS-1:0] long_flag,
    output logic [NUM_KEYS-1:0] repeat_flag,
    output logic [NUM_KEYS-1:0] key_state
);

    localparam int DBC_W = $clog2(DEBOUNCE_CYCLES);
    // One extra code so the long counter can park past its terminal value and fire only once.
    localparam int LPC_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LPC_W-1:0] LPC_LAST = LPC_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [LPC_W-1:0] LPC_SAT  = LPC_W'(LONG_PRESS_CYCLES);

    localparam logic [NUM_KEYS-1:0] RELEASED_PIN = {NUM_KEYS{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        P_FILTER = 2'd1,
        PRESSED  = 2'd2,
        R_FILTER = 2'd3
    } state_t;

    logic [NUM_KEYS-1:0] sync_r0;
    logic [NUM_KEYS-1:0] sync_r1;
    logic [NUM_KEYS-1:0] sync_r2;
    logic [NUM_KEYS-1:0] pressed_now;
    logic [NUM_KEYS-1:0] pressed_prev;
    logic [NUM_KEYS-1:0] press_edge;
    logic [NUM_KEYS-1:0] release_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r0 <= RELEASED_PIN;
            sync_r1 <= RELEASED_PIN;
            sync_r2 <= RELEASED_PIN;
        end else begin
            sync_r0 <= key;
            sync_r1 <= sync_r0;
            sync_r2 <= sync_r1;
        end
    end

    assign pressed_now  = sync_r1 ^ RELEASED_PIN;
    assign pressed_prev = sync_r2 ^ RELEASED_PIN;
    assign press_edge   = pressed_now & ~pressed_prev;
    assign release_edge = ~pressed_now & pressed_prev;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic [DBC_W-1:0] dbc;
        logic [DBC_W-1:0] dbc_nxt;
        logic [LPC_W-1:0] lpc;
        logic [LPC_W-1:0] lpc_nxt;
        logic             press_q;
        logic             press_nxt;
        logic             release_q;
        logic             release_nxt;
        logic             long_q;
        logic             long_nxt;
        logic             level_q;
        logic             level_nxt;

        // An edge arriving on the terminal count always wins: the filter backs out with no flag.
        always_comb begin
            state_nxt   = state;
            dbc_nxt     = dbc;
            lpc_nxt     = lpc;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            long_nxt    = 1'b0;
            level_nxt   = level_q;
            case (state)
                IDLE: begin
                    if (press_edge[i]) begin
                        state_nxt = P_FILTER;
                        dbc_nxt   = '0;
                    end
                end
                P_FILTER: begin
                    if (release_edge[i]) begin
                        state_nxt = IDLE;
                    end else if (dbc == DBC_LAST) begin
                        state_nxt = PRESSED;
                        press_nxt = 1'b1;
                        level_nxt = 1'b1;
                        lpc_nxt   = '0;
                    end else begin
                        dbc_nxt = dbc + 1'b1;
                    end
                end
                PRESSED: begin
                    if (release_edge[i]) begin
                        state_nxt = R_FILTER;
                        dbc_nxt   = '0;
                    end else if (lpc != LPC_SAT) begin
                        lpc_nxt  = lpc + 1'b1;
                        long_nxt = (lpc == LPC_LAST);
                    end
                end
                R_FILTER: begin
                    // A bounce back to pressed resumes the long-press count where it left off.
                    if (press_edge[i]) begin
                        state_nxt = PRESSED;
                    end else if (dbc == DBC_LAST) begin
                        state_nxt   = IDLE;
                        release_nxt = 1'b1;
                        level_nxt   = 1'b0;
                    end else begin
                        dbc_nxt = dbc + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    level_nxt = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state     <= IDLE;
                dbc       <= '0;
                lpc       <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                level_q   <= 1'b0;
            end else begin
                state     <= state_nxt;
                dbc       <= dbc_nxt;
                lpc       <= lpc_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                long_q    <= long_nxt;
                level_q   <= level_nxt;
            end
        end

        assign press_flag[i]   = press_q;
        assign release_flag[i] = release_q;
        assign long_flag[i]    = long_q;
        assign key_state[i]    = level_q;

`ifdef KEY_REPEAT_EN
        localparam int RPC_W = $clog2(REPEAT_CYCLES);
        localparam logic [RPC_W-1:0] RPC_LAST = RPC_W'(REPEAT_CYCLES - 1);

        logic [RPC_W-1:0] rpc;
        logic [RPC_W-1:0] rpc_nxt;
        logic             repeat_q;
        logic             repeat_nxt;

        // Repeat period starts counting only once the long-press counter has parked.
        always_comb begin
            rpc_nxt    = rpc;
            repeat_nxt = 1'b0;
            if (state_nxt == IDLE) begin
                rpc_nxt = '0;
            end else if (state == PRESSED && state_nxt == PRESSED && lpc == LPC_SAT) begin
                if (rpc == RPC_LAST) begin
                    rpc_nxt    = '0;
                    repeat_nxt = 1'b1;
                end else begin
                    rpc_nxt = rpc + 1'b1;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rpc      <= '0;
                repeat_q <= 1'b0;
            end else begin
                rpc      <= rpc_nxt;
                repeat_q <= repeat_nxt;
            end
        end

        assign repeat_flag[i] = repeat_q;
`else
        assign repeat_flag[i] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_key_filter_multi.sv
module tb_key_filter_multi;

    localparam int NK = 2;
    localparam int DB = 4;
    localparam int LP = 20;
    localparam int RP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key = '1;
    logic [NK-1:0] press_flag;
    logic [NK-1:0] release_flag;
    logic [NK-1:0] long_flag;
    logic [NK-1:0] repeat_flag;
    logic [NK-1:0] key_state;

    key_filter_multi #(
        .NUM_KEYS          (NK),
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP),
        .REPEAT_CYCLES     (RP),
        .ACTIVE_LOW        (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key          (key),
        .press_flag   (press_flag),
        .release_flag (release_flag),
        .long_flag    (long_flag),
        .repeat_flag  (repeat_flag),
        .key_state    (key_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] v;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] obs;

    assign obs = {press_flag, release_flag, long_flag, repeat_flag};

    // Scoreboard: every cycle with any flag high consumes the oldest expected event.
    always @(negedge clk) begin
        if (obs !== 8'h00) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL unexpected_flag cyc=%0d observed=%h expected=none", cyc, obs);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                vectors++;
                assert ({cyc, obs} === {mon_e.cyc, mon_e.v}) else begin
                    miscompares++;
                    $error("FAIL flag_event observed cyc=%0d flags=%h expected cyc=%0d flags=%h",
                           cyc, obs, mon_e.cyc, mon_e.v);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic void expect_ev(input int t, input logic [7:0] v);
        ev_t e;
        e.cyc = t;
        e.v   = v;
        exp_q.push_back(e);
    endfunction

    task automatic drive(input int ch, input bit pressed);
        key[ch] = ~pressed;
    endtask

    // Clean press of channel ch held h cycles; g>0 injects a one-cycle release glitch at offset g.
    task automatic press_hold(input int ch, input int h, input int g, input string tag);
        int         c = cyc;
        int         l;
        logic [1:0] m;
        m = 2'b01 << ch;
        l = (g > 0) ? LP + 7 + 2 : LP + 7;
        expect_ev(c + 7, {m, 6'b0});
        if (l < h + 3) expect_ev(c + l, {4'b0, m, 2'b0});
`ifdef KEY_REPEAT_EN
        for (int t = l + RP; t < h + 3; t += RP) expect_ev(c + t, {6'b0, m});
`endif
        expect_ev(c + h + 7, {2'b0, m, 4'b0});
        drive(ch, 1'b1);
        for (int i = 1; i <= h; i++) begin
            @(negedge clk);
            if (g > 0 && i == g) drive(ch, 1'b0);
            if (g > 0 && i == g + 1) drive(ch, 1'b1);
            if (i == 8 && h >= 8) check({tag, "_state_held"}, key_state, m);
        end
        drive(ch, 1'b0);
        repeat (10) @(negedge clk);
        check({tag, "_state_released"}, key_state, 0);
        check({tag, "_events_left"}, exp_q.size(), 0);
    endtask

    task automatic bounce(input int ch, input int n, input string tag);
        drive(ch, 1'b1);
        repeat (n) @(negedge clk);
        drive(ch, 1'b0);
        repeat (12) @(negedge clk);
        check({tag, "_state"}, key_state, 0);
        check({tag, "_events_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int c;
        repeat (3) @(negedge clk);
        check("reset_flags", obs, 0);
        check("reset_state", key_state, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        press_hold(0, 40, 0, "hold40");
        bounce(0, 2, "bounce2");
        bounce(0, 4, "bounce4_terminal");
        press_hold(0, 5, 0, "hold5_min");
        press_hold(0, 60, 0, "hold60");
        press_hold(0, 40, 12, "glitch");
        press_hold(1, 30, 0, "ch1_hold30");

        c = cyc;
        drive(0, 1'b1);
        drive(1, 1'b1);
        expect_ev(c + 7, 8'b1100_0000);
        repeat (10) @(negedge clk);
        check("both_state", key_state, 2'b11);
        rst = 1'b1;
        key = '1;
        @(negedge clk);
        check("midpress_rst_flags", obs, 0);
        check("midpress_rst_state", key_state, 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("after_rst_state", key_state, 0);
        check("after_rst_events_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
